fcp_volt_negotiator: RTL and testbench
======================================

FCP_VOLT_NEGOTIATOR -- requirements
Module: fcp_volt_negotiator

Interface
REQ-001 Parameter NUM_LVL, default 3, number of output voltage levels (2..8); level 0 = 5 V, ascending.
REQ-002 Parameter VSEL_W, default 2, width of out_volt; SHALL satisfy 2^VSEL_W >= NUM_LVL.
REQ-003 Parameter STEP_DWELL, default 1000, clock cycles between consecutive level steps (>=1).
REQ-004 Parameter WDT_CYC, default 50000, idle cycles without master activity before fallback to level 0 (>=2).
REQ-005 Parameter DEV_ID, default 8'h00, value returned on device-ID read.
REQ-006 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-007 rstn  in  1  asynchronous, active-low reset.
REQ-008 lvl_support  in  NUM_LVL  per-level support mask; bit 0 SHALL be treated as 1 regardless of input.
REQ-009 ping_from_master  in  1  one-cycle pulse, master ping detected.
REQ-010 reset_from_master  in  1  one-cycle pulse, master bus reset detected.
REQ-011 rx_data  in  24  received frame {cmd[23:16], addr[15:8], wdata[7:0]}, valid with rx_data_valid.
REQ-012 rx_data_valid  in  1  one-cycle frame strobe.
REQ-013 crc_error, par_error  in  1 each  error flags qualifying the frame in the rx_data_valid cycle.
REQ-014 tx_done  in  1  one-cycle pulse, physical layer finished the current response.
REQ-015 pl_tx_en  out  1  response request, held until tx_done.
REQ-016 pl_tx_type  out  1  0 = ACK/NACK only, 1 = ACK plus data byte.
REQ-017 pl_tx_data  out  16  {code[15:8], rdata[7:0]}; code 8'h08 = ACK, 8'h03 = NACK.
REQ-018 out_volt  out  VSEL_W  current applied level.
REQ-019 volt_busy  out  1  high while out_volt != target level.
REQ-020 wdt_expired  out  1  one-cycle pulse on watchdog fallback.

Function
REQ-021 Frame with crc_error or par_error SHALL produce NACK, no register effect.
REQ-022 cmd 8'h0C (write), addr 8'h2C: if wdata < NUM_LVL and lvl_support[wdata] is 1, target <= wdata and ACK; else NACK, target unchanged.
REQ-023 cmd 8'h0B (read): addr 8'h00 returns DEV_ID; addr 8'h21 returns lvl_support zero-extended to 8 bits (bit 0 forced 1); both ACK with pl_tx_type=1.
REQ-024 Any other cmd/addr combination SHALL produce NACK with pl_tx_type=0, rdata 8'h00.
REQ-025 Tx FSM TX_IDLE -> TX_WAIT one cycle after accepted rx_data_valid; pl_tx_en/type/data registered and stable in TX_WAIT; TX_WAIT -> TX_IDLE on tx_done, pl_tx_en low the following cycle.
REQ-026 rx_data_valid arriving while in TX_WAIT SHALL be dropped entirely (no register or watchdog effect).
REQ-027 Ramp FSM R_IDLE/R_DWELL: when out_volt != target, enter R_DWELL, count STEP_DWELL cycles, then step out_volt by exactly 1 toward target; repeat until equal, then R_IDLE.
REQ-028 Target change mid-ramp SHALL NOT restart the dwell count; direction is re-evaluated at each step boundary.
REQ-029 Watchdog counts only while target != 0; cleared by ping_from_master or an accepted frame; at WDT_CYC sets target to 0 (ramp down per REQ-027) and pulses wdt_expired.
REQ-030 Ping and watchdog terminal count in the same cycle: ping wins, no expiry.
REQ-031 reset_from_master SHALL, next edge: target=0, out_volt=0 immediately (no ramp), watchdog cleared, Tx FSM to TX_IDLE, pl_tx_en low; it overrides a simultaneous rx_data_valid.

Reset
REQ-032 rstn low SHALL asynchronously set out_volt=0, target=0, pl_tx_en=0, pl_tx_type=0, pl_tx_data=16'h0000, volt_busy=0, wdt_expired=0, both FSMs idle, all counters 0.

Verification
REQ-033 Write 0x0C/0x2C/0x02 with lvl_support=3'b111, STEP_DWELL=4 -> ACK {08,00}; out_volt 0->1 after 4 cycles, 1->2 after 4 more; volt_busy high throughout.
REQ-034 Write level 2 with lvl_support=3'b011 -> NACK {03,00}, out_volt stays 0; read 0x0B/0x21 -> type 1, {08,03}.
REQ-035 Frame with par_error=1 -> NACK; second frame during TX_WAIT -> no second response, no target change.
REQ-036 At level 2, no ping for WDT_CYC=20 cycles -> wdt_expired pulse, ramp 2->1->0; repeat with ping on terminal cycle -> no expiry.
REQ-037 Mid-ramp (out_volt=1, target=2) reset_from_master -> out_volt=0 next cycle, pl_tx_en=0; rstn low mid-TX_WAIT -> all outputs to REQ-032 values asynchronously.

Source files
------------

// File: rtl/fcp_volt_negotiator_if.sv
// Link between the FCP physical layer and the voltage negotiator: received
// frames and master events in, response requests out.
interface fcp_volt_negotiator_if;
  logic [23:0] rx_data;
  logic        rx_data_valid;
  logic        crc_error;
  logic        par_error;
  logic        tx_done;
  logic        ping_from_master;
  logic        reset_from_master;
  logic        pl_tx_en;
  logic        pl_tx_type;
  logic [15:0] pl_tx_data;

  modport master (
    output rx_data, rx_data_valid, crc_error, par_error, tx_done,
           ping_from_master, reset_from_master,
    input  pl_tx_en, pl_tx_type, pl_tx_data
  );

  modport slave (
    input  rx_data, rx_data_valid, crc_error, par_error, tx_done,
           ping_from_master, reset_from_master,
    output pl_tx_en, pl_tx_type, pl_tx_data
  );
endinterface

// File: rtl/fcp_volt_negotiator.sv
// FCP sink-side voltage negotiator: decodes master frames, answers ACK/NACK,
// ramps the output level one step per dwell period and falls back on idle.
module fcp_volt_negotiator #(
  parameter int           NUM_LVL    = 3,
  parameter int           VSEL_W     = 2,
  parameter int           STEP_DWELL = 1000,
  parameter int           WDT_CYC    = 50000,
  parameter logic [7:0]   DEV_ID     = 8'h00
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_LVL-1:0]   lvl_support,
  fcp_volt_negotiator_if.slave bus,
  output logic [VSEL_W-1:0]    out_volt,
  output logic                 volt_busy,
  output logic                 wdt_expired
);

  localparam logic [7:0] CMD_WR    = 8'h0C;
  localparam logic [7:0] CMD_RD    = 8'h0B;
  localparam logic [7:0] ADDR_VSEL = 8'h2C;
  localparam logic [7:0] ADDR_ID   = 8'h00;
  localparam logic [7:0] ADDR_CAP  = 8'h21;
  localparam logic [7:0] CODE_ACK  = 8'h08;
  localparam logic [7:0] CODE_NACK = 8'h03;
  localparam int         DW_W      = $clog2(STEP_DWELL + 1);
  localparam int         WD_W      = $clog2(WDT_CYC + 1);

  typedef enum logic { TX_IDLE, TX_WAIT } tx_state_t;
  typedef enum logic { R_IDLE, R_DWELL } ramp_state_t;

  tx_state_t           tx_state, tx_next;
  ramp_state_t         ramp_state, ramp_next;
  logic [VSEL_W-1:0]   target;
  logic [DW_W-1:0]     dwell_cnt;
  logic [WD_W-1:0]     wdt_cnt;
  logic [NUM_LVL-1:0]  support_eff;
  logic [7:0]          cmd, addr, wdata;
  logic                lvl_ok, wr_vsel, rsp_type, accept, step;
  logic [15:0]         rsp_data;

  assign {cmd, addr, wdata} = bus.rx_data;
  assign support_eff = lvl_support | NUM_LVL'(1);
  assign accept      = bus.rx_data_valid && (tx_state == TX_IDLE) && !bus.reset_from_master;
  assign volt_busy   = (out_volt != target);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lvl_ok = 1'b0;
    for (int i = 0; i < NUM_LVL; i++) begin
      if (wdata == 8'(i) && support_eff[i]) lvl_ok = 1'b1;
    end
  end

  // Errored frames fall through to the NACK default.
  always_comb begin
    rsp_type = 1'b0;
    rsp_data = {CODE_NACK, 8'h00};
    wr_vsel  = 1'b0;
    if (!(bus.crc_error || bus.par_error)) begin
      if (cmd == CMD_WR && addr == ADDR_VSEL && lvl_ok) begin
        rsp_data = {CODE_ACK, 8'h00};
        wr_vsel  = 1'b1;
      end else if (cmd == CMD_RD && addr == ADDR_ID) begin
        rsp_type = 1'b1;
        rsp_data = {CODE_ACK, DEV_ID};
      end else if (cmd == CMD_RD && addr == ADDR_CAP) begin
        rsp_type = 1'b1;
        rsp_data = {CODE_ACK, 8'(support_eff)};
      end
    end
  end

  // ---------------- Tx FSM ----------------
  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    if (bus.reset_from_master) tx_next = TX_IDLE;
    else begin
      case (tx_state)
        TX_IDLE: if (bus.rx_data_valid) tx_next = TX_WAIT;
        TX_WAIT: if (bus.tx_done)       tx_next = TX_IDLE;
        default: tx_next = TX_IDLE;
      endcase
    end
  end

  always_comb bus.pl_tx_en = (tx_state == TX_WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.pl_tx_type <= 1'b0;
      bus.pl_tx_data <= 16'h0000;
    end else if (accept) begin
      bus.pl_tx_type <= rsp_type;
      bus.pl_tx_data <= rsp_data;
    end
  end

  // ---------------- Ramp FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ramp_state <= R_IDLE;
    else       ramp_state <= ramp_next;
  end

  always_comb begin
    ramp_next = ramp_state;
    if (bus.reset_from_master) ramp_next = R_IDLE;
    else begin
      case (ramp_state)
        R_IDLE:  if (volt_busy)  ramp_next = R_DWELL;
        R_DWELL: if (!volt_busy) ramp_next = R_IDLE;
        default: ramp_next = R_IDLE;
      endcase
    end
  end

  // The cycle a mismatch first appears already counts toward the dwell.
  always_comb step = volt_busy && (dwell_cnt == DW_W'(STEP_DWELL - 1));

  // ---------------- Level, dwell and watchdog datapath ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_volt    <= '0;
      target      <= '0;
      dwell_cnt   <= '0;
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
    end else if (bus.reset_from_master) begin
      out_volt    <= '0;
      target      <= '0;
      dwell_cnt   <= '0;
      wdt_cnt     <= '0;
      wdt_expired <= 1'b0;
    end else begin
      wdt_expired <= 1'b0;

      if (step) begin
        out_volt  <= (out_volt < target) ? out_volt + 1'b1 : out_volt - 1'b1;
        dwell_cnt <= '0;
      end else if (volt_busy) begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end else begin
        dwell_cnt <= '0;
      end

      // Master activity beats a same-cycle terminal count.
      if (bus.ping_from_master || accept) begin
        wdt_cnt <= '0;
      end else if (target != '0) begin
        if (wdt_cnt == WD_W'(WDT_CYC - 1)) begin
          wdt_cnt     <= '0;
          wdt_expired <= 1'b1;
          target      <= '0;
        end else begin
          wdt_cnt <= wdt_cnt + 1'b1;
        end
      end else begin
        wdt_cnt <= '0;
      end

      if (accept && wr_vsel) target <= VSEL_W'(wdata);
    end
  end

endmodule

// File: tb/tb_fcp_volt_negotiator.sv
// Directed bench for fcp_volt_negotiator: a cycle-level behavioural model is
// compared every cycle, and literal expectations pin the key timing points.
module tb_fcp_volt_negotiator;
  localparam int         NUM_LVL    = 3;
  localparam int         VSEL_W     = 2;
  localparam int         STEP_DWELL = 4;
  localparam int         WDT_CYC    = 20;
  localparam logic [7:0] DEV_ID     = 8'hA5;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NUM_LVL-1:0] lvl_support;
  logic [VSEL_W-1:0]  out_volt;
  logic               volt_busy;
  logic               wdt_expired;

  int checks   = 0;
  int failures = 0;

  fcp_volt_negotiator_if bus();

  fcp_volt_negotiator #(
    .NUM_LVL(NUM_LVL), .VSEL_W(VSEL_W), .STEP_DWELL(STEP_DWELL),
    .WDT_CYC(WDT_CYC), .DEV_ID(DEV_ID)
  ) dut (
    .clk(clk), .rstn(rstn), .lvl_support(lvl_support), .bus(bus.slave),
    .out_volt(out_volt), .volt_busy(volt_busy), .wdt_expired(wdt_expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_target = 0, m_volt = 0, m_dwell = 0, m_idle = 0;
  bit          m_tx_busy = 0, m_pulse = 0, m_type = 0;
  logic [15:0] m_data = 16'h0000;

  function automatic void respond(input logic [23:0] f, input bit err, input logic [2:0] sup,
                                  output bit typ, output logic [15:0] data, output bit wr);
    logic [7:0] c, a, d, cap;
    {c, a, d} = f;
    cap  = {5'b00000, sup | 3'b001};
    typ  = 1'b0;
    data = 16'h0300;
    wr   = 1'b0;
    if (!err) begin
      if (c == 8'h0C && a == 8'h2C && d < NUM_LVL && cap[d[2:0]]) begin
        data = 16'h0800;
        wr   = 1'b1;
      end else if (c == 8'h0B && a == 8'h00) begin
        typ = 1'b1; data = {8'h08, DEV_ID};
      end else if (c == 8'h0B && a == 8'h21) begin
        typ = 1'b1; data = {8'h08, cap};
      end
    end
  endfunction

  initial forever begin : model
    bit accept, wr, typ;
    logic [15:0] data;
    int new_target;
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_target = 0; m_volt = 0; m_dwell = 0; m_idle = 0;
      m_tx_busy = 0; m_pulse = 0; m_type = 0; m_data = 16'h0000;
    end else begin
      accept  = bus.rx_data_valid && !m_tx_busy && !bus.reset_from_master;
      m_pulse = 0;
      if (bus.reset_from_master) begin
        m_target = 0; m_volt = 0; m_dwell = 0; m_idle = 0; m_tx_busy = 0;
      end else begin
        new_target = m_target;
        // m_dwell = cycles elapsed since the last step while off target
        if (m_volt != m_target) begin
          m_dwell++;
          if (m_dwell == STEP_DWELL) begin
            m_volt  = m_volt + ((m_target > m_volt) ? 1 : -1);
            m_dwell = 0;
          end
        end else m_dwell = 0;
        // m_idle = cycles since the last master activity while on a raised level
        if (bus.ping_from_master || accept || m_target == 0) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == WDT_CYC) begin
            m_idle = 0; m_pulse = 1; new_target = 0;
          end
        end
        if (accept) begin
          respond(bus.rx_data, bus.crc_error | bus.par_error, lvl_support, typ, data, wr);
          m_tx_busy = 1; m_type = typ; m_data = data;
          if (wr) new_target = int'(bus.rx_data[7:0]);
        end else if (m_tx_busy && bus.tx_done) begin
          m_tx_busy = 0;
        end
        m_target = new_target;
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    check("cmp_out_volt", 32'(out_volt), 32'(m_volt));
    check("cmp_volt_busy", 32'(volt_busy), 32'(m_volt != m_target));
    check("cmp_wdt_expired", 32'(wdt_expired), 32'(m_pulse));
    check("cmp_pl_tx_en", 32'(bus.pl_tx_en), 32'(m_tx_busy));
    if (m_tx_busy) begin
      check("cmp_pl_tx_type", 32'(bus.pl_tx_type), 32'(m_type));
      check("cmp_pl_tx_data", 32'(bus.pl_tx_data), 32'(m_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                       input bit crc = 1'b0, input bit par = 1'b0);
    bus.rx_data = {c, a, d}; bus.crc_error = crc; bus.par_error = par;
    bus.rx_data_valid = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0; bus.crc_error = 1'b0; bus.par_error = 1'b0;
  endtask

  task automatic done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  initial begin
    bus.rx_data = '0; bus.rx_data_valid = 1'b0; bus.crc_error = 1'b0; bus.par_error = 1'b0;
    bus.tx_done = 1'b0; bus.ping_from_master = 1'b0; bus.reset_from_master = 1'b0;
    lvl_support = 3'b011;
    tick(2);
    check("rst_out_volt", 32'(out_volt), 0);
    check("rst_pl_tx_en", 32'(bus.pl_tx_en), 0);
    check("rst_pl_tx_data", 32'(bus.pl_tx_data), 0);
    rstn = 1'b1;
    tick();

    // unsupported level, reads, unknown address, out-of-range level
    frame(8'h0C, 8'h2C, 8'h02);
    check("nack_unsupported", 32'(bus.pl_tx_data), 32'h0300);
    check("nack_unsupported_type", 32'(bus.pl_tx_type), 0);
    done(); tick(5);
    check("unsupported_no_ramp", 32'(out_volt), 0);
    frame(8'h0B, 8'h21, 8'h00);
    check("read_cap_type", 32'(bus.pl_tx_type), 1);
    check("read_cap_data", 32'(bus.pl_tx_data), 32'h0803);
    done();
    frame(8'h0B, 8'h00, 8'h00);
    check("read_id_data", 32'(bus.pl_tx_data), 32'h08A5);
    done();
    frame(8'h0B, 8'h55, 8'h00);
    check("unknown_addr", 32'(bus.pl_tx_data), 32'h0300);
    check("unknown_addr_type", 32'(bus.pl_tx_type), 0);
    done();
    frame(8'h0C, 8'h2C, 8'h03);
    check("nack_out_of_range", 32'(bus.pl_tx_data), 32'h0300);
    done();

    // errored frame, then a good frame dropped while the response is pending
    frame(8'h0C, 8'h2C, 8'h01, 1'b0, 1'b1);
    check("nack_parity", 32'(bus.pl_tx_data), 32'h0300);
    frame(8'h0C, 8'h2C, 8'h01);
    check("dropped_keeps_rsp", 32'(bus.pl_tx_data), 32'h0300);
    done();
    check("tx_en_low_after_done", 32'(bus.pl_tx_en), 0);
    tick(6);
    check("dropped_no_second_rsp", 32'(bus.pl_tx_en), 0);
    check("dropped_no_target", 32'(volt_busy), 0);
    frame(8'h0C, 8'h2C, 8'h01, 1'b1, 1'b0);
    check("nack_crc", 32'(bus.pl_tx_data), 32'h0300);
    done(); tick(2);
    check("crc_no_target", 32'(out_volt), 0);

    // ramp 0->2, then watchdog fallback 2->0
    lvl_support = 3'b111;
    frame(8'h0C, 8'h2C, 8'h02);                 // now 1 after edge E0
    check("ack_write", 32'(bus.pl_tx_data), 32'h0800);
    check("busy_after_write", 32'(volt_busy), 1);
    done(); tick(2);                            // E3
    check("ramp_e3", 32'(out_volt), 0);
    tick();                                     // E4
    check("ramp_e4_step1", 32'(out_volt), 1);
    check("ramp_e4_busy", 32'(volt_busy), 1);
    tick(3);
    check("ramp_e7", 32'(out_volt), 1);
    tick();                                     // E8
    check("ramp_e8_step2", 32'(out_volt), 2);
    check("ramp_e8_idle", 32'(volt_busy), 0);
    tick(11);                                   // E19
    check("wdt_e19_quiet", 32'(wdt_expired), 0);
    tick();                                     // E20
    check("wdt_e20_pulse", 32'(wdt_expired), 1);
    tick();
    check("wdt_pulse_one_cycle", 32'(wdt_expired), 0);
    tick(3);                                    // E24
    check("fallback_step1", 32'(out_volt), 1);
    tick(4);                                    // E28
    check("fallback_step0", 32'(out_volt), 0);

    // ping on the terminal cycle suppresses expiry
    frame(8'h0C, 8'h2C, 8'h02);
    done(); tick(18);                           // E19
    bus.ping_from_master = 1'b1;
    tick();                                     // E20
    bus.ping_from_master = 1'b0;
    check("ping_wins_no_pulse", 32'(wdt_expired), 0);
    tick();
    check("ping_wins_level", 32'(out_volt), 2);

    // master reset mid-ramp, overriding a simultaneous frame
    bus.reset_from_master = 1'b1; tick(); bus.reset_from_master = 1'b0;
    check("mreset_to_zero", 32'(out_volt), 0);
    frame(8'h0C, 8'h2C, 8'h02);
    done(); tick(4);                            // E5
    check("midramp_level", 32'(out_volt), 1);
    bus.reset_from_master = 1'b1;
    bus.rx_data = {8'h0C, 8'h2C, 8'h01}; bus.rx_data_valid = 1'b1;
    tick();
    bus.reset_from_master = 1'b0; bus.rx_data_valid = 1'b0;
    check("mreset_out_volt", 32'(out_volt), 0);
    check("mreset_busy", 32'(volt_busy), 0);
    check("mreset_tx_en", 32'(bus.pl_tx_en), 0);
    tick();
    check("mreset_frame_ignored", 32'(bus.pl_tx_en), 0);
    frame(8'h0B, 8'h00, 8'h00);
    check("pending_before_mreset", 32'(bus.pl_tx_en), 1);
    bus.reset_from_master = 1'b1; tick(); bus.reset_from_master = 1'b0;
    check("mreset_clears_tx_en", 32'(bus.pl_tx_en), 0);

    // asynchronous rstn while a response is pending mid-ramp
    frame(8'h0C, 8'h2C, 8'h02);
    done(); tick(5);
    frame(8'h0B, 8'h21, 8'h00);
    #1 rstn = 1'b0;
    #1;
    check("arst_out_volt", 32'(out_volt), 0);
    check("arst_busy", 32'(volt_busy), 0);
    check("arst_tx_en", 32'(bus.pl_tx_en), 0);
    check("arst_tx_type", 32'(bus.pl_tx_type), 0);
    check("arst_tx_data", 32'(bus.pl_tx_data), 0);
    check("arst_wdt", 32'(wdt_expired), 0);
    tick();
    rstn = 1'b1;
    tick(3);
    check("post_reset_level", 32'(out_volt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
